// File: rtl/vs_pkg.sv
// Shared types and constants for the folded vector-scalar unit.
// Optional multiply saturation is selected with VS_SEQ_SAT_EN (see vs_lane_unit).
package vs_pkg;

   localparam int unsigned VS_LANES  = 24;
   localparam int unsigned VS_LANE_W = 8;

   typedef enum logic [2:0] {
      FN_BCAST = 3'b001,
      FN_MUL   = 3'b100,
      FN_DIV   = 3'b110
   } funct_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   // True for the three supported operation codes.
   function automatic logic funct_legal(input logic [2:0] f);
      return (f == 3'(FN_BCAST)) || (f == 3'(FN_MUL)) || (f == 3'(FN_DIV));
   endfunction

endpackage

// File: rtl/vs_lane_unit.sv
// Single-lane combinational vector-scalar op.
// VS_SEQ_SAT_EN defined: multiply saturates to all-ones; undefined: multiply truncates.
module vs_lane_unit
   import vs_pkg::*;
#(
   parameter int unsigned LANE_W = VS_LANE_W
) (
   input  logic [2:0]        funct,
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   output logic [LANE_W-1:0] y,
   output logic              dz
);

   localparam int unsigned PW = 2 * LANE_W;

   logic [PW-1:0] prod;

   assign prod = PW'(a) * PW'(b);

   always_comb begin
      y  = '0;
      dz = 1'b0;
      case (funct)
         FN_BCAST: y = b;
         FN_MUL: begin
`ifdef VS_SEQ_SAT_EN
            y = (prod > PW'({LANE_W{1'b1}})) ? '1 : LANE_W'(prod);
`else
            y = LANE_W'(prod);
`endif
         end
         FN_DIV: begin
            // Divide by zero yields all-ones rather than an undefined quotient.
            if (b == '0) begin
               y  = '1;
               dz = 1'b1;
            end else begin
               y = a / b;
            end
         end
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/vs_lane_sequencer.sv
// Folded vector-scalar controller: walks GROUP lanes per cycle through vs_lane_unit.
// Multiply saturation is enabled by defining VS_SEQ_SAT_EN.
module vs_lane_sequencer
   import vs_pkg::*;
#(
   parameter int unsigned LANES  = VS_LANES,
   parameter int unsigned LANE_W = VS_LANE_W,
   parameter int unsigned GROUP  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2:0]              funct,
   input  logic [LANES*LANE_W-1:0] vec_in,
   input  logic [LANE_W-1:0]       scalar_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*LANE_W-1:0] result,
   output logic                    div_zero,
   output logic                    illegal
);

   localparam int unsigned NG    = LANES / GROUP;
   localparam int unsigned CNT_W = (NG > 1) ? $clog2(NG) : 1;
   localparam int unsigned VEC_W = LANES * LANE_W;
   localparam int unsigned GW    = GROUP * LANE_W;

   localparam logic [1:0] S_IDLE = 2'(IDLE);
   localparam logic [1:0] S_BUSY = 2'(BUSY);
   localparam logic [1:0] S_DONE = 2'(DONE);

   logic [1:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_funct;
   logic [VEC_W-1:0]  op_vec;
   logic [LANE_W-1:0] op_scalar;
   logic [GW-1:0]     grp_a, grp_y;
   logic [GROUP-1:0]  grp_dz;
   logic              accept;
   logic              legal;

   assign in_ready  = (state == S_IDLE) && rst_n;
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid && in_ready;
   assign legal     = funct_legal(funct);
   assign grp_a     = op_vec[int'(cnt)*GW +: GW];

   for (genvar g = 0; g < GROUP; g++) begin : g_lane
      vs_lane_unit #(.LANE_W(LANE_W)) u_lane (
         .funct (op_funct),
         .a     (grp_a[g*LANE_W +: LANE_W]),
         .b     (op_scalar),
         .y     (grp_y[g*LANE_W +: LANE_W]),
         .dz    (grp_dz[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = legal ? S_BUSY : S_DONE;
         S_BUSY:  if (cnt == CNT_W'(NG - 1)) state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, per-group result write and flag tracking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         op_funct  <= '0;
         op_vec    <= '0;
         op_scalar <= '0;
         result    <= '0;
         div_zero  <= 1'b0;
         illegal   <= 1'b0;
      end else if (state == S_IDLE) begin
         if (accept) begin
            op_funct  <= funct;
            op_vec    <= vec_in;
            op_scalar <= scalar_in;
            cnt       <= '0;
            result    <= '0;
            illegal   <= !legal;
            div_zero  <= legal && (funct == 3'(FN_DIV)) && (scalar_in == '0);
         end
      end else if (state == S_BUSY) begin
         result[int'(cnt)*GW +: GW] <= grp_y;
         cnt      <= cnt + CNT_W'(1);
         div_zero <= div_zero | (|grp_dz);
      end
   end

endmodule

// File: doc/vs_lane_sequencer.md
Name: vs_lane_sequencer

Overview:
- Folded vector-scalar execution controller for the 24-lane × 8-bit vector unit; processes GROUP lanes per cycle instead of all 24 combinationally.
- Accepts one op (funct, 192-bit vector, scalar) over a valid/ready handshake, sequences lane groups through a small datapath, then presents the full result over a valid/ready handshake.
- Sits between the vector issue stage and the vector register-file write port.

Parameters:
- LANES, 24, number of vector lanes
- LANE_W, 8, bits per lane
- GROUP, 4, lanes processed per cycle; must divide LANES (NG = LANES/GROUP = 6)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  op request
- in_ready  out  1  sequencer can accept an op
- funct  in  3  3'b001 broadcast, 3'b100 multiply, 3'b110 divide
- vec_in  in  LANES*LANE_W  vector operand; lane i = bits [i*LANE_W +: LANE_W]
- scalar_in  in  LANE_W  scalar operand
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  LANES*LANE_W  per-lane result
- div_zero  out  1  divide op with scalar == 0
- illegal  out  1  funct not one of the three codes

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; group counter 0; result 0; div_zero 0; illegal 0; out_valid 0. in_ready = (state == IDLE) && rst_n.
- Reset mid-operation abandons the op. No partial result is ever presented.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch funct, vec_in, scalar_in; clear result and flags; counter = 0.
  - Next state: BUSY for a legal funct; DONE with illegal = 1 and result = 0 otherwise.
- BUSY:
  - Each cycle, write lanes [counter*GROUP, counter*GROUP+GROUP-1] of result from the latched operands; counter increments.
  - After the write with counter == NG-1, go to DONE.
  - in_ready = 0; out_valid = 0.
- DONE:
  - out_valid = 1; result and flags are held stable.
  - On out_ready, go to IDLE.
  - in_ready = 0; no same-cycle re-accept.
- Latency, legal op: out_valid rises NG+1 = 7 cycles after the accepting edge.
- Latency, illegal op: out_valid rises 1 cycle after the accepting edge.
- Throughput: one op per NG+2 cycles minimum.
- Lane arithmetic, all operands unsigned:
  - broadcast: lane = scalar.
  - multiply: lane = low LANE_W bits of the 2*LANE_W-bit product.
  - divide: lane = floor(lane_in / scalar).
- Divide by zero: every lane = all-ones (8'hFF); div_zero = 1 from entry into BUSY until leaving DONE.
- Flags are valid only while out_valid is high; they clear on the next accept.
- out_ready high while not in DONE: ignored.
- in_valid high while in_ready is low: ignored; the requester must hold in_valid.

Optional Feature:
- Macro: VS_SEQ_SAT_EN.
- Defined: multiply saturates; any product > 2^LANE_W-1 gives lane = all-ones.
- Undefined: multiply truncates to the low LANE_W bits.
- Broadcast and divide are unaffected either way.

Decomposition:
- Package vs_pkg:
  - funct_e enum: FN_BCAST = 3'b001, FN_MUL = 3'b100, FN_DIV = 3'b110.
  - seq_state_e enum: IDLE, BUSY, DONE.
  - Constants VS_LANES = 24 and VS_LANE_W = 8.
- Sub-module vs_lane_unit:
  - Combinational single-lane op: funct, a, b → y, dz.
  - Contains the saturation `ifdef.
  - Instantiated GROUP times inside vs_lane_sequencer.

Test Plan:
- Multiply: all lanes 8'h03, scalar 8'h05, out_ready = 1 → out_valid exactly 7 cycles after accept; every lane 8'h0F; div_zero = 0; illegal = 0.
- Truncate/saturate: lane0 8'h20, scalar 8'h10, multiply → lane0 8'h00 without VS_SEQ_SAT_EN; 8'hFF with it.
- Divide: lanes i = i*10, scalar 8'h07 → lane i = floor(i*10/7), e.g. lane 23 = 8'h20.
- Divide by zero: scalar 0 → all lanes 8'hFF; div_zero = 1.
- Illegal funct: funct 3'b010 → out_valid 1 cycle after accept; illegal = 1; result 0.
- Backpressure: out_ready low 5 cycles in DONE → result/flags stable and in_ready = 0 throughout; accept completes on the out_ready cycle.
- Reset mid-op: rst_n low at BUSY counter = 3 → next cycle IDLE, out_valid = 0, result = 0; a fresh op then completes normally.
